// File: rtl/muldiv_sequencer_pkg.sv
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared types and constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_sequencer_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int MULDIV_CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_datapath.sv
// ============================================================================
// Module      : muldiv_iter_datapath
// Description : hi/lo/operand registers with one radix-2 shift-add or
//               restoring shift-subtract step per strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            div_i,
  input  logic [XLEN-1:0] load_hi_i,
  input  logic [XLEN-1:0] load_lo_i,
  input  logic [XLEN-1:0] load_m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] m_q,  m_d;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Multiply: hi accumulates, lo shifts the multiplier out LSB-first.
  // Divide: {hi,lo} shifts left, hi is the partial remainder, lo the quotient.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, m_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    if (clear_i) begin
      hi_d = '0;
      lo_d = '0;
      m_d  = '0;
    end else if (load_i) begin
      hi_d = load_hi_i;
      lo_d = load_lo_i;
      m_d  = load_m_i;
    end else if (step_i) begin
      if (div_i) begin
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[XLEN:1];
        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle RV32M multiply/divide sequencer beside EX.
//               Optional MULDIV_FAST_MUL_EN: single-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  muldiv_op_e      op_q,    op_d;
  logic            neg_q,   neg_d;

  muldiv_op_e      op_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic            dp_clear, dp_load, dp_step;
  logic [XLEN-1:0] ld_hi, ld_lo, ld_m;
  logic [XLEN-1:0] hi, lo;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0] res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fprod;
`endif

  always_comb begin
    op_in    = muldiv_op_e'(op_i);
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed & operand_a_i[XLEN-1];
    b_neg    = b_signed & operand_b_i[XLEN-1];
    a_mag    = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
    b_mag    = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
    div_zero = op_in[2] && (operand_b_i == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (operand_a_i == MIN_NEG) && (operand_b_i == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fa    = {a_signed & operand_a_i[XLEN-1], operand_a_i};
    fb    = {b_signed & operand_b_i[XLEN-1], operand_b_i};
    fprod = $signed({{(XLEN-1){fa[XLEN]}}, fa}) * $signed({{(XLEN-1){fb[XLEN]}}, fb});
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dp_clear = 1'b0;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    ld_hi    = '0;
    ld_lo    = '0;
    ld_m     = '0;
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      dp_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_d    = op_in;
            dp_load = 1'b1;
            if (div_zero || div_ovf) begin
              // Architected special results are loaded raw and bypass sign fix-up.
              state_d = DONE;
              neg_d   = 1'b0;
              ld_hi   = div_zero ? operand_a_i : '0;
              ld_lo   = div_zero ? '1 : MIN_NEG;
            end else if (op_in[2]) begin
              state_d = CALC;
              cnt_d   = CNT_W'(XLEN - 1);
              neg_d   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
              ld_lo   = a_mag;
              ld_m    = b_mag;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              state_d = DONE;
              neg_d   = 1'b0;
              ld_hi   = fprod[2*XLEN-1:XLEN];
              ld_lo   = fprod[XLEN-1:0];
`else
              state_d = CALC;
              cnt_d   = CNT_W'(XLEN - 1);
              neg_d   = a_neg ^ b_neg;
              ld_lo   = b_mag;
              ld_m    = a_mag;
`endif
            end
          end
        end
        CALC: begin
          dp_step = 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  muldiv_iter_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (dp_clear),
    .load_i    (dp_load),
    .step_i    (dp_step),
    .div_i     (op_q[2]),
    .load_hi_i (ld_hi),
    .load_lo_i (ld_lo),
    .load_m_i  (ld_m),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  // Result depends only on registered state; flush merely masks it.
  always_comb begin
    prod_c = neg_q ? (~{hi, lo} + 1'b1) : {hi, lo};
    res    = '0;
    case (op_q)
      OP_MUL:                        res = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res = prod_c[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               res = neg_q ? (~lo + 1'b1) : lo;
      OP_REM, OP_REMU:               res = neg_q ? (~hi + 1'b1) : hi;
      default:                       res = '0;
    endcase
  end

  assign stall_o  = rst_n & start_i & ~flush_i & (state_q != DONE);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE) & ~flush_i;
  assign result_o = done_o ? res : '0;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench with expected-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  int          vectors = 0;
  int          fails   = 0;
  int          cyc     = 0;
  int          done_a, done_b;
  logic [31:0] sb_q[$];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; the op's cycle 0 is the current cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold, output int done_cyc);
    bit          seen;
    logic [31:0] exp_r;
    sb_q.push_back(exp);
    start_i = 1'b1; flush_i = 1'b0;
    op_i = op; operand_a_i = a; operand_b_i = b;
    seen = 1'b0;
    done_cyc = -1;
    for (int k = 0; k <= lat + 3; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_busy_c0"}, {31'd0, busy_o}, 32'd0);
      if (done_o === 1'b1) begin
        exp_r = sb_q.pop_front();
        chk({tag, "_result"}, result_o, exp_r);
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        done_cyc = cyc;
        seen = 1'b1;
        break;
      end
      chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
      @(posedge clk); #1;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
    end
    if (!seen) begin
      vectors++;
      void'(sb_q.pop_front());
      assert (seen) else begin
        fails++;
        $error("FAIL %s_timeout: observed no done_o expected done_o by cycle %0d", tag, lat);
      end
    end
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = 3'd0; operand_a_i = '0; operand_b_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",  {31'd0, stall_o}, 32'd0);
    chk("rst_busy",   {31'd0, busy_o},  32'd0);
    chk("rst_done",   {31'd0, done_o},  32'd0);
    chk("rst_result", result_o,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0, done_a);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0, done_a);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 0, done_a);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0, done_a);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT, 0, done_a);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT, 0, done_a);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,        DIV_LAT, 0, done_a);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,         DIV_LAT, 0, done_a);
    run_op("div0",   3'b100, 32'h1234,     32'd0,        32'hFFFF_FFFF, 1, 0, done_a);
    run_op("rem0",   3'b110, 32'h1234,     32'd0,        32'h0000_1234, 1, 0, done_a);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, done_a);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, done_a);

    // Flush a DIV on its cycle 10, then restart on cycle 11.
    start_i = 1'b1; op_i = 3'b100; operand_a_i = 32'd1000; operand_b_i = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("flush_nodone", {31'd0, done_o}, 32'd0);
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_done",  {31'd0, done_o},  32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    run_op("after_flush", 3'b100, 32'd1000, 32'd3, 32'd333, DIV_LAT, 0, done_a);

    // Asynchronous reset in the middle of CALC.
    start_i = 1'b1; op_i = 3'b101; operand_a_i = 32'd100; operand_b_i = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stall",  {31'd0, stall_o}, 32'd0);
    chk("midrst_busy",   {31'd0, busy_o},  32'd0);
    chk("midrst_done",   {31'd0, done_o},  32'd0);
    chk("midrst_result", result_o,         32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back DIVU then MUL with start_i held.
    run_op("b2b_divu", 3'b101, 32'd100, 32'd7,        32'd14,        DIV_LAT, 1, done_a);
    run_op("b2b_mul",  3'b000, 32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0, done_b);
    chk("b2b_spacing", done_b - done_a, MUL_LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Multi-cycle RV32M multiply/divide unit beside the execute stage.
- Accepts one M-extension operation per request, using operands after forwarding, and iterates a radix-2 shift-add / restoring-divide datapath.
- Holds the pipeline with `stall_o` until the result is ready.
- Its result is muxed into the EX/MEM ALU-result field by execute on the `done_o` cycle.

## Interface
Parameters:
- XLEN, default `DATA_WIDTH (32): operand and result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  an M-type instruction occupies EX; held high while stalled.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a_i  in  XLEN  rs1 value after forwarding.
- operand_b_i  in  XLEN  rs2 value after forwarding.
- flush_i  in  1  EX flush (branch redirect); aborts any operation.
- stall_o  out  1  stall IF/ID/EX; combinational.
- busy_o  out  1  state != IDLE.
- done_o  out  1  result_o valid this cycle.
- result_o  out  XLEN  final result; zero when done_o=0.

## Operation
States:
- IDLE
  - start_i & !flush_i: latch op and operands.
  - Compute magnitudes and result sign.
  - Go to DONE for special cases (below), otherwise to CALC; counter=XLEN-1.
- CALC: one iteration per cycle, counter decrements; at counter==0 go to DONE.
- DONE
  - done_o=1; result_o = sign-corrected selected half (product lo/hi, quotient, remainder).
  - Always returns to IDLE next cycle.

Arithmetic:
- Multiply: unsigned 2·XLEN accumulator of magnitudes.
  - MULH negates if signs differ.
  - MULHSU treats operand_b as unsigned.
- Divide: restoring divide on magnitudes.
  - Quotient negated if signs differ (signed ops).
  - Remainder takes the dividend's sign.

Special cases (IDLE→DONE directly, no CALC):
- Divisor 0: quotient all-ones, remainder = dividend.
- Signed overflow (0x8000_0000 / −1): quotient 0x8000_0000, remainder 0.

Control rules:
- stall_o = start_i & !flush_i & (state != DONE).
- flush_i in any state:
  - Next state IDLE; counter cleared; done_o forced 0.
  - flush_i has priority over start_i.
- Operands are sampled only in IDLE; later changes on the inputs are ignored.
- start_i dropping mid-CALC without flush_i is a protocol error: the operation completes, done_o pulses, and the result is discarded by execute.
- Reset mid-operation: immediate return to IDLE; no done_o.

## Timing
Reset values: state IDLE, counter 0, stall_o 0, busy_o 0, done_o 0, result_o 0.

Latency is counted from the first cycle start_i is seen in IDLE, called cycle 0:
- Iterative op: CALC on cycles 1..XLEN, DONE on cycle XLEN+1; stall_o high on cycles 0..XLEN.
- Special case: DONE on cycle 1; stall_o high on cycle 0 only.
- Back-to-back M ops: DONE→IDLE gives exactly one IDLE cycle. The next instruction's cycle 0 is the cycle after DONE, so there is no bubble beyond the stall itself.
- result_o is registered-state-derived, with no combinational path from operand inputs; done_o likewise.

## Configuration
MULDIV_FAST_MUL_EN:
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle XLEN×XLEN signed multiply in IDLE.
  - The registered product is delivered in DONE on cycle 1.
  - Divide ops are unchanged.
- Undefined: all multiplies iterate XLEN cycles like divides; no hardware multiplier is inferred.

## Structure
- Shared header common/pipeline_types.svh gains:
  - muldiv_op_e, the funct3 enum above.
  - muldiv_state_e {IDLE, CALC, DONE}.
  - Constant MULDIV_CNT_W = $clog2(XLEN).
- Sub-module muldiv_iter_datapath holds the accumulator/remainder/quotient registers and the one-step shift-add / shift-subtract logic.
  - Controlled by step/load/clear strobes from the sequencer FSM.

## Test plan
- MUL 7×−3 → done_o on cycle 33 (on cycle 1 with fast-mul); result 0xFFFF_FFEB; stall_o high on cycles 0..32.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE; MULH same operands → 0x0000_0000; MULHSU −1×0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU → 2; each finishes on cycle 33.
- DIV x/0 with x=0x1234 → 0xFFFF_FFFF and REM → 0x1234 on cycle 1; DIV 0x8000_0000/−1 → 0x8000_0000 and REM → 0 on cycle 1.
- flush_i on cycle 10 of a DIV → IDLE on cycle 11; no done_o; a new start on cycle 11 completes normally with correct result.
- rst_n low on cycle 5 of CALC → all outputs 0 immediately; back-to-back DIVU then MUL with no gap → two done_o pulses exactly 34 cycles apart (iterative).
